// File: rtl/npu_mac_pkg.sv
// Shared types and constants for the MAC array drain path.
package npu_mac_pkg;

    localparam int unsigned BF16_W = 16;

    localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;

    // Collector control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } collect_state_e;

    // Clamp any value with the sign bit set (including -0 and negative NaN) to +0.
    function automatic logic [BF16_W-1:0] bf16_relu(input logic [BF16_W-1:0] x);
        return x[BF16_W-1] ? BF16_ZERO : x;
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous DEPTH x BF16 FIFO with a registered head entry.
// Pointers carry one extra wrap bit; full when the index bits match and the wrap bits differ.
module mac_result_fifo
    import npu_mac_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BF16_W-1:0] push_data,
    input  logic              pop,
    output logic              full_c,
    output logic              empty_c,
    output logic [BF16_W-1:0] head_data,
    output logic              head_valid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [BF16_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_n;
    logic [PW-1:0]     rd_ptr_n;
    logic [BF16_W-1:0] head_data_n;
    logic              head_valid_n;
    logic              push_ok;
    logic              pop_ok;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign pop_ok  = pop && !empty_c;
    assign push_ok = push && (!full_c || pop_ok);

    // Next pointers and the entry that will sit at the head after this edge.
    always_comb begin
        wr_ptr_n     = push_ok ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_n     = pop_ok  ? rd_ptr + PW'(1) : rd_ptr;
        head_valid_n = (wr_ptr_n != rd_ptr_n);
        head_data_n  = head_data;
        if (head_valid_n) begin
            // The slot being written becomes the head only when the FIFO drains to it.
            if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
                head_data_n = push_data;
            end else begin
                head_data_n = mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_data  <= BF16_ZERO;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            head_data  <= head_data_n;
            head_valid <= head_valid_n;
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// Time-driven capture of BF16 partial sums from the last cell of a MAC column.
// After start, waits acc_len + PIPE_LAT cycles, then pushes num_results consecutive
// c_in samples into a small FIFO drained over a valid/ready stream.
// Optional: define MAC_COLLECT_RELU_EN to zero negative results on the output path.
module mac_result_collector
    import npu_mac_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CW       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        acc_len,
    input  logic [CW-1:0]     num_results,
    input  logic [BF16_W-1:0] c_in,
    output logic [BF16_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned WCW = 9;

    collect_state_e    state;
    collect_state_e    state_n;
    logic [WCW-1:0]    wait_cnt;
    logic [WCW-1:0]    wait_cnt_n;
    logic [CW-1:0]     cap_cnt;
    logic [CW-1:0]     cap_cnt_n;
    logic              done_n;
    logic              overflow_n;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [BF16_W-1:0] head_data;

    assign pop_c  = out_ready && !fifo_empty_c;
    assign drop_c = push_c && fifo_full_c && !pop_c;

    // Next-state, counter and flag logic.
    // WAIT hands over to CAPTURE one edge early so the first push lands exactly
    // acc_len + PIPE_LAT edges after the accepting edge.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        cap_cnt_n  = cap_cnt;
        done_n     = 1'b0;
        overflow_n = overflow;
        push_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = WAIT;
                    wait_cnt_n = WCW'(acc_len) + WCW'(PIPE_LAT - 1);
                    cap_cnt_n  = num_results;
                    overflow_n = 1'b0;
                end
            end
            WAIT: begin
                wait_cnt_n = (wait_cnt == '0) ? '0 : wait_cnt - WCW'(1);
                if (wait_cnt <= WCW'(1)) begin
                    if (cap_cnt == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                push_c    = 1'b1;
                cap_cnt_n = cap_cnt - CW'(1);
                if (cap_cnt == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (drop_c) begin
            overflow_n = 1'b1;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            cap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            cap_cnt  <= cap_cnt_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            overflow <= overflow_n;
        end
    end

    mac_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_data  (c_in),
        .pop        (pop_c),
        .full_c     (fifo_full_c),
        .empty_c    (fifo_empty_c),
        .head_data  (head_data),
        .head_valid (out_valid)
    );

    // Output path; stored entries are always raw.
`ifdef MAC_COLLECT_RELU_EN
    assign out_data = bf16_relu(head_data);
`else
    assign out_data = head_data;
`endif

endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Drain-side companion of the MAC array: after a tile's operands have been fed, it waits out the accumulation and pipeline latency, samples the BF16 partial sums leaving the last cell of one array column, and buffers them in a small FIFO. Downstream logic (writeback, activation unit) reads them over a valid/ready stream. Because the MAC cells cannot stall, capture is time-driven and never back-pressured. A full FIFO drops the sample and raises a sticky flag.

## Interface
- PIPE_LAT, 3: cycles from the last operand pair entering the column to the matching sum appearing on c_in (multiplier plus the cell's two accumulation stages).
- DEPTH, 8: FIFO entries; power of two, ≥2.
- CW, 4: width of num_results.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to collect a tile; honoured only in IDLE.
- acc_len  in  8  accumulation cycles of the tile; sampled with start.
- num_results  in  CW  consecutive sums to capture; sampled with start.
- c_in  in  16  BF16 sum from the column's last mac cell (its c_out).
- out_data  out  16  BF16 result at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts; a pop happens when out_valid && out_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the capture window ends.
- overflow  out  1  sticky; set on a dropped sample, cleared by an accepted start.

## Operation
- FSM states and transitions:
  - IDLE: start moves to WAIT and loads wait_cnt = acc_len + PIPE_LAT − 1 (9-bit) and cap_cnt = num_results. It also clears overflow.
  - WAIT: wait_cnt decrements each cycle. At 0, move to CAPTURE, or straight to IDLE with done if cap_cnt == 0.
  - CAPTURE: each cycle, push c_in and decrement cap_cnt. On the last push, return to IDLE and assert done.
- start is ignored in WAIT and CAPTURE, with no side effects.
- FIFO push when full and no pop that cycle: sample dropped, overflow set, FIFO unchanged.
- FIFO push when full with a pop that same cycle: both happen and nothing is dropped.
- Pop when empty: no effect.
- The FIFO contents persist across tiles. IDLE with a non-empty FIFO is legal.
- out_data must stay stable while out_valid && !out_ready.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full means the low bits are equal and the MSBs differ.

## Timing
- Reset values: out_data 0, out_valid 0, busy 0, done 0, overflow 0. FSM in IDLE, FIFO empty, counters 0.
- Let E be the edge that accepts start. The first capture is c_in sampled at edge E + acc_len + PIPE_LAT. The remaining num_results − 1 captures follow on consecutive edges.
- busy is high from the cycle after E through the cycle of the last capture edge.
- done is high for exactly the cycle following the last capture edge.
- Push-to-visibility latency: a value pushed at edge N drives out_data/out_valid after edge N (registered head). It is poppable at edge N+1.
- Reset mid-operation (WAIT or CAPTURE): immediate return to IDLE, FIFO emptied, no done pulse.

## Configuration
- MAC_COLLECT_RELU_EN defined: out_data is forced to 16'h0000 whenever the head entry's sign bit is set. This covers −0 and negative NaN. The ReLU is applied on the output path only; stored data is unchanged.
- Not defined: out_data is the raw stored value.

## Structure
- Shared package npu_mac_pkg holds:
  - BF16_W = 16;
  - the collector state enum (IDLE, WAIT, CAPTURE);
  - BF16_ZERO = 16'h0000.
- One sub-module, mac_result_fifo: a synchronous DEPTH×16 FIFO with push, pop, full, empty and registered head.
- mac_result_collector keeps the FSM, counters, the overflow flag and the optional ReLU mux.

## Test plan
- Basic capture: PIPE_LAT=3, start with acc_len=4, num_results=3; c_in ramps 16'h3F80, 16'h4000, 16'h4040 at E+7..E+9; out_ready=1. Required: out_data 3F80, 4000, 4040 in order; done at E+10.
- Back-pressure: out_ready=0, num_results=8. Required: FIFO full, out_valid held, out_data stable at the first value. Then release: 8 pops, no overflow.
- Overflow: FIFO preloaded with 8 entries, out_ready=0, num_results=2. Required: both samples dropped, overflow=1. The next accepted start clears it.
- Simultaneous push/pop when full: FIFO full with out_ready=1 during a capture window. Required: no drop, order preserved, overflow=0.
- Corner cases:
  - num_results=0: done one cycle after the WAIT expiry, nothing pushed.
  - start during WAIT: ignored.
  - rst_n pulsed low during CAPTURE: all outputs return to reset values and there is no done pulse.
- MAC_COLLECT_RELU_EN: pushing 16'hBF80 then 16'h3F80 yields out_data 0000 then 3F80. With the macro undefined, the same stimulus yields BF80 then 3F80.
